// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: receive side of a VGA link.
// Resynchronises hsync/vsync/pixel, recovers the raster position, measures
// line and frame timing against the expected mode, and presents the active
// area as a pixel stream with coordinates once the timing has locked.
//
// Handshake: pix_valid has no ready. Each cycle with pix_valid = 1 carries
// one active-area pixel (pix_data at pix_x/pix_y), and the sink must take it.
module vga_sync_decoder #(
    parameter int H_TOTAL         = 800,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int H_ACTIVE        = 640,
    parameter int V_TOTAL         = 525,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int V_ACTIVE        = 480,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int LOCK_FRAMES     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [2:0] pixel_in,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [2:0] pix_data,
    output logic       frame_start,
    output logic       locked,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines,
    output logic       timing_err,
    output logic [1:0] dbg_state
);

    localparam logic [9:0] CNT_MAX     = 10'd1023;
    localparam logic [9:0] H_TOTAL_W   = 10'(H_TOTAL);
    localparam logic [9:0] V_TOTAL_W   = 10'(V_TOTAL);
    localparam logic [9:0] H_START     = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_END       = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] V_START     = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_END       = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_FRAMES);
    localparam logic       SYNC_INV    = (SYNC_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Input pipeline: polarity is normalised on entry so 1 always means asserted
    logic       hs_s1_q, hs_s2_q;
    logic       vs_s1_q, vs_s2_q;
    logic [2:0] pix_s1_q, pix_s2_q;

    // Raster counters and measurements; hcnt_q/vcnt_q describe the pixel in pix_s2_q
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic [9:0] line_len_q, line_len_d;
    logic [9:0] frame_lines_q, frame_lines_d;
    logic       vpend_q, vpend_d;
    logic       frame_start_q;

    // Lock FSM
    state_t     state_q;
    logic [3:0] good_cnt_q;
    logic       locked_q;
    logic       timing_err_q;

    // Output stage
    logic       pix_valid_q;
    logic [9:0] pix_x_q, pix_y_q;
    logic [2:0] pix_data_q;

    // Combinational helpers
    logic       hedge, vedge, fs_d;
    logic [9:0] hcnt_inc, vcnt_inc;
    logic       line_bad, frame_bad, sync_lost;
    logic       gain_lock, lose_lock, locked_nxt;
    logic       h_win, v_win;

    // Two-flop resynchroniser; all three inputs share the same delay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_s1_q  <= 1'b0;
            hs_s2_q  <= 1'b0;
            vs_s1_q  <= 1'b0;
            vs_s2_q  <= 1'b0;
            pix_s1_q <= 3'd0;
            pix_s2_q <= 3'd0;
        end else begin
            hs_s1_q  <= hsync_in ^ SYNC_INV;
            hs_s2_q  <= hs_s1_q;
            vs_s1_q  <= vsync_in ^ SYNC_INV;
            vs_s2_q  <= vs_s1_q;
            pix_s1_q <= pixel_in;
            pix_s2_q <= pix_s1_q;
        end
    end

    // Edge detection, counter next values, timing measurements and lock decisions
    always_comb begin
        hedge    = hs_s1_q & ~hs_s2_q;
        vedge    = vs_s1_q & ~vs_s2_q;
        hcnt_inc = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 10'd1;
        vcnt_inc = (vcnt_q == CNT_MAX) ? CNT_MAX : vcnt_q + 10'd1;
        fs_d     = hedge & (vpend_q | vedge);

        hcnt_d        = hedge ? 10'd0 : hcnt_inc;
        line_len_d    = hedge ? hcnt_inc : line_len_q;
        vcnt_d        = vcnt_q;
        frame_lines_d = frame_lines_q;
        vpend_d       = vpend_q;
        if (fs_d) begin
            vcnt_d        = 10'd0;
            frame_lines_d = vcnt_inc;
            vpend_d       = 1'b0;
        end else begin
            if (hedge) begin
                vcnt_d = vcnt_inc;
            end
            if (vedge) begin
                vpend_d = 1'b1;
            end
        end

        line_bad  = hedge & (line_len_d != H_TOTAL_W);
        frame_bad = fs_d & (frame_lines_d != V_TOTAL_W);
        sync_lost = (hcnt_d == CNT_MAX) | (vcnt_d == CNT_MAX);

        gain_lock  = (state_q == CHECK) & fs_d & ~line_bad & ~frame_bad &
                     ((good_cnt_q + 4'd1) == LOCK_TARGET);
        lose_lock  = (state_q == LOCKED) & (line_bad | frame_bad | sync_lost);
        locked_nxt = (locked_q & ~lose_lock) | gain_lock;

        h_win = (hcnt_q >= H_START) && (hcnt_q < H_END);
        v_win = (vcnt_q >= V_START) && (vcnt_q < V_END);
    end

    // Raster counters, measured line/frame lengths and the frame-start pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q        <= 10'd0;
            vcnt_q        <= 10'd0;
            line_len_q    <= 10'd0;
            frame_lines_q <= 10'd0;
            vpend_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            vpend_q       <= vpend_d;
            frame_start_q <= fs_d;
        end
    end

    // Lock FSM: one partial frame is skipped in SEARCH, CHECK counts good frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SEARCH;
            good_cnt_q   <= 4'd0;
            locked_q     <= 1'b0;
            timing_err_q <= 1'b0;
        end else begin
            timing_err_q <= 1'b0;
            case (state_q)
                SEARCH: begin
                    if (fs_d) begin
                        state_q    <= CHECK;
                        good_cnt_q <= 4'd0;
                    end
                end
                CHECK: begin
                    if (line_bad || frame_bad) begin
                        state_q <= SEARCH;
                    end else if (gain_lock) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                    end else if (fs_d) begin
                        good_cnt_q <= good_cnt_q + 4'd1;
                    end
                end
                LOCKED: begin
                    if (lose_lock) begin
                        state_q      <= SEARCH;
                        locked_q     <= 1'b0;
                        timing_err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= SEARCH;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    // Output stage: one register after the pipeline, so data/coords/valid align
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid_q <= 1'b0;
            pix_x_q     <= 10'd0;
            pix_y_q     <= 10'd0;
            pix_data_q  <= 3'd0;
        end else begin
            pix_valid_q <= h_win & v_win & locked_nxt;
            pix_x_q     <= hcnt_q - H_START;
            pix_y_q     <= vcnt_q - V_START;
            pix_data_q  <= pix_s2_q;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_data    = pix_data_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign timing_err  = timing_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced video mode
// (40 clocks x 20 lines) so that many frames fit in a short run.
module tb_vga_sync_decoder;

  localparam int HT = 40;
  localparam int HS = 4;
  localparam int HB = 4;
  localparam int HA = 24;
  localparam int VT = 20;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VA = 12;
  localparam int HSTART = HS + HB;
  localparam int VSTART = VS + VB;

  logic       clk;
  logic       rst_n;
  logic       hsync_in;
  logic       vsync_in;
  logic [2:0] pixel_in;
  logic       pix_valid;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [2:0] pix_data;
  logic       frame_start;
  logic       locked;
  logic [9:0] line_len;
  logic [9:0] frame_lines;
  logic       timing_err;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // monitor state
  int cyc = 0;
  int fs_cnt = 0;
  int err_cnt = 0;
  int beat_cnt = 0;
  int beat_bad = 0;
  int lock_rise_cnt = 0;
  int lock_at_fs = 0;
  int err_fs = 0;
  int err_line_len = 0;
  int err_frame_lines = 0;
  int first_x = -1;
  int first_y = -1;
  int first_cyc = 0;
  int src_origin_cyc = 0;
  bit need_first = 0;
  bit locked_prev = 0;

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA),
    .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .hsync_in(hsync_in),
    .vsync_in(vsync_in),
    .pixel_in(pixel_in),
    .pix_valid(pix_valid),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .pix_data(pix_data),
    .frame_start(frame_start),
    .locked(locked),
    .line_len(line_len),
    .frame_lines(frame_lines),
    .timing_err(timing_err),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // monitor: event counters sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_start) begin
        fs_cnt++;
        need_first = 1;
      end
      if (locked && !locked_prev) begin
        lock_rise_cnt++;
        lock_at_fs = fs_cnt;
      end
      if (timing_err) begin
        err_cnt++;
        err_fs = fs_cnt;
        err_line_len = int'(line_len);
        err_frame_lines = int'(frame_lines);
      end
      if (pix_valid) begin
        beat_cnt++;
        if (pix_data != pix_x[2:0] || pix_x >= 10'(HA) || pix_y >= 10'(VA)) beat_bad++;
        if (need_first) begin
          first_x = int'(pix_x);
          first_y = int'(pix_y);
          first_cyc = cyc;
          need_first = 0;
        end
      end
    end
    locked_prev = locked;
  end

  // driver tasks (sync pins are active low)
  task automatic drive_cycle(input bit hs, input bit vs, input logic [2:0] px);
    @(posedge clk);
    #1;
    hsync_in = ~hs;
    vsync_in = ~vs;
    pixel_in = px;
  endtask

  task automatic drive_line(input int v, input bit suppress);
    logic [2:0] px;
    for (int h = 0; h < HT; h++) begin
      if (h >= HSTART && h < HSTART + HA && v >= VSTART && v < VSTART + VA)
        px = 3'(h - HSTART);
      else
        px = 3'($urandom_range(0, 7));
      drive_cycle((h < HS) && !suppress, v < VS, px);
      if (h == HSTART && v == VSTART) src_origin_cyc = cyc;
    end
  endtask

  task automatic drive_frame(input int nlines, input int suppress_line);
    for (int v = 0; v < nlines; v++) drive_line(v, v == suppress_line);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_pix_valid"}, pix_valid, 0);
    check({pfx, "_pix_x"}, pix_x, 0);
    check({pfx, "_pix_y"}, pix_y, 0);
    check({pfx, "_pix_data"}, pix_data, 0);
    check({pfx, "_frame_start"}, frame_start, 0);
    check({pfx, "_locked"}, locked, 0);
    check({pfx, "_line_len"}, line_len, 0);
    check({pfx, "_frame_lines"}, frame_lines, 0);
    check({pfx, "_timing_err"}, timing_err, 0);
    check({pfx, "_state"}, dbg_state, 0);
  endtask

  int fs_base;
  int rise_base;

  initial begin
    rst_n = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    pixel_in = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ideal stream, 4 frames
    for (int f = 0; f < 4; f++) drive_frame(VT, -1);
    @(negedge clk);
    check("s1_lock_at_fs", lock_at_fs, 3);
    check("s1_locked", locked, 1);
    check("s1_line_len", line_len, HT);
    check("s1_frame_lines", frame_lines, VT);
    check("s1_timing_err_cnt", err_cnt, 0);
    check("s1_beats", beat_cnt, 2 * HA * VA);
    check("s1_first_x", first_x, 0);
    check("s1_first_y", first_y, 0);
    check("s1_first_latency", first_cyc - src_origin_cyc, 3);

    // one suppressed hsync pulse while locked
    drive_frame(VT, 10);
    @(negedge clk);
    check("s2_err_cnt", err_cnt, 1);
    check("s2_err_line_len", err_line_len, 2 * HT);
    check("s2_locked", locked, 0);
    for (int f = 0; f < 3; f++) drive_frame(VT, -1);
    @(negedge clk);
    check("s2_relock", locked, 1);
    check("s2_relock_fs", lock_at_fs - err_fs, 3);

    // short frames: error on the first, never relock afterwards
    rise_base = lock_rise_cnt;
    for (int f = 0; f < 5; f++) drive_frame(VT - 1, -1);
    @(negedge clk);
    check("s3_err_cnt", err_cnt, 2);
    check("s3_err_frame_lines", err_frame_lines, VT - 1);
    check("s3_frame_lines", frame_lines, VT - 1);
    check("s3_locked", locked, 0);
    check("s3_no_relock", lock_rise_cnt, rise_base);

    // recover lock, then lose hsync entirely
    for (int f = 0; f < 4; f++) drive_frame(VT, -1);
    @(negedge clk);
    check("s4_locked_before", locked, 1);
    for (int i = 0; i < 1100; i++) drive_cycle(1'b0, 1'b0, 3'($urandom_range(0, 7)));
    @(negedge clk);
    check("s4_err_cnt", err_cnt, 3);
    check("s4_locked", locked, 0);
    check("s4_pix_valid", pix_valid, 0);

    // asynchronous reset in the middle of a line
    drive_frame(VT, -1);
    for (int h = 0; h < 20; h++) drive_cycle(h < HS, 1'b1, 3'd5);
    @(negedge clk);
    check("s5_line_len_pre", line_len, HT);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("s5_async");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    fs_base = fs_cnt;
    for (int f = 0; f < 4; f++) drive_frame(VT, -1);
    @(negedge clk);
    check("s5_lock_at_fs", lock_at_fs - fs_base, 3);
    check("s5_locked", locked, 1);
    check("s5_err_cnt", err_cnt, 3);
    check("beat_data_bad", beat_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
